// File: rtl/display_pkg.sv
// Shared display encodings: source/state codes and message nibble patterns
// used by the display arbiter and the vending FSM.
package display_pkg;

    localparam logic [1:0] SRC_CREDIT = 2'b00;
    localparam logic [1:0] SRC_PRICE  = 2'b01;
    localparam logic [1:0] SRC_MSG    = 2'b10;

    // State codes double as the src output encoding.
    typedef enum logic [1:0] {
        ST_CREDIT = SRC_CREDIT,
        ST_PRICE  = SRC_PRICE,
        ST_MSG    = SRC_MSG
    } disp_state_t;

    localparam logic [15:0] MSG_SOLD = 16'h5010;
    localparam logic [15:0] MSG_ERR  = 16'hE770;
    localparam logic [15:0] MSG_FULL = 16'hF511;

endpackage

// File: rtl/tick_timer.sv
// 16-bit tick-driven down-counter. Load has priority over tick; a tick at
// zero reloads the counter and pulses expire in that same cycle.
module tick_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);

    logic [W-1:0] count_q;

    assign expire = tick && (count_q == '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (tick) begin
            count_q <= (count_q == '0) ? load_val : count_q - 1'b1;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the 4-digit display between live credit, a timed price preview
// and a timed (optionally blinking) status message. All outputs registered.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned HOLD_MS  = 2000,
    parameter int unsigned BLINK_MS = 250
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tick_1ms,
    input  logic [15:0] credit_bcd,
    input  logic        price_req,
    input  logic [15:0] price_bcd,
    input  logic        msg_req,
    input  logic [15:0] msg_code,
    input  logic        msg_blink,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic [3:0]  dig4,
    output logic        blank,
    output logic [1:0]  src,
    output logic        busy
);

    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_MS - 1);
    localparam logic [15:0] BLINK_LOAD = 16'(BLINK_MS - 1);

    disp_state_t state_q, state_n;
    logic [15:0] price_q, price_n;
    logic [15:0] msg_q, msg_n;
    logic        blink_q, blink_n;
    logic        pending_q, pending_n;
    logic        phase_q, phase_n;
    logic [15:0] dig_q, dig_n;
    logic        blank_q, blank_n;

    logic hold_load, hold_tick, hold_expire;
    logic blink_load, blink_tick, blink_expire;

    // A price request during MSG does not reload the hold timer, so it must
    // not swallow a tick that lands in the same cycle.
    assign hold_tick  = tick_1ms && !msg_req && !(price_req && state_q != ST_MSG);
    assign blink_tick = tick_1ms && (state_q == ST_MSG) && blink_q;

    tick_timer #(.W(16)) u_hold (
        .clk      (clk),
        .clr      (clr),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .tick     (hold_tick),
        .expire   (hold_expire)
    );

    tick_timer #(.W(16)) u_blink (
        .clk      (clk),
        .clr      (clr),
        .load     (blink_load),
        .load_val (BLINK_LOAD),
        .tick     (blink_tick),
        .expire   (blink_expire)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_CREDIT;
            price_q   <= '0;
            msg_q     <= '0;
            blink_q   <= 1'b0;
            pending_q <= 1'b0;
            phase_q   <= 1'b0;
            dig_q     <= '0;
            blank_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            price_q   <= price_n;
            msg_q     <= msg_n;
            blink_q   <= blink_n;
            pending_q <= pending_n;
            phase_q   <= phase_n;
            dig_q     <= dig_n;
            blank_q   <= blank_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        price_n    = price_q;
        msg_n      = msg_q;
        blink_n    = blink_q;
        pending_n  = pending_q;
        phase_n    = phase_q;
        hold_load  = 1'b0;
        blink_load = 1'b0;

        if (msg_req) begin
            state_n    = ST_MSG;
            msg_n      = msg_code;
            blink_n    = msg_blink;
            phase_n    = 1'b1;
            hold_load  = 1'b1;
            blink_load = 1'b1;
            if (price_req) begin
                price_n   = price_bcd;
                pending_n = 1'b1;
            end else if (state_q != ST_MSG) begin
                pending_n = 1'b0;
            end
        end else if (price_req && state_q != ST_MSG) begin
            state_n   = ST_PRICE;
            price_n   = price_bcd;
            pending_n = 1'b0;
            hold_load = 1'b1;
        end else begin
            if (price_req) begin
                price_n   = price_bcd;
                pending_n = 1'b1;
            end
            if (state_q == ST_MSG && blink_q && blink_expire) begin
                phase_n = ~phase_q;
            end
            if (hold_expire) begin
                case (state_q)
                    ST_MSG: begin
                        if (pending_n) begin
                            state_n   = ST_PRICE;
                            pending_n = 1'b0;
                            hold_load = 1'b1;
                        end else begin
                            state_n = ST_CREDIT;
                        end
                    end
                    ST_PRICE: state_n = ST_CREDIT;
                    default:  state_n = state_q;
                endcase
            end
        end

        case (state_n)
            ST_PRICE: dig_n = price_n;
            ST_MSG:   dig_n = msg_n;
            default:  dig_n = credit_bcd;
        endcase
        blank_n = (state_n == ST_MSG) && blink_n && !phase_n;
    end

    assign dig1  = dig_q[15:12];
    assign dig2  = dig_q[11:8];
    assign dig3  = dig_q[7:4];
    assign dig4  = dig_q[3:0];
    assign blank = blank_q;
    assign src   = state_q;
    assign busy  = (state_q != ST_CREDIT);

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_MS=4, BLINK_MS=2 and one
// tick_1ms pulse every 10 clocks.
module tb_display_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        tick_1ms = 1'b0;
    logic [15:0] credit_bcd = '0;
    logic        price_req = 1'b0;
    logic [15:0] price_bcd = '0;
    logic        msg_req = 1'b0;
    logic [15:0] msg_code = '0;
    logic        msg_blink = 1'b0;
    logic [3:0]  dig1, dig2, dig3, dig4;
    logic        blank;
    logic [1:0]  src;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic blank_pre;
    logic [15:0] dig_all;

    assign dig_all = {dig1, dig2, dig3, dig4};

    display_arbiter #(.HOLD_MS(4), .BLINK_MS(2)) dut (
        .clk        (clk),
        .clr        (clr),
        .tick_1ms   (tick_1ms),
        .credit_bcd (credit_bcd),
        .price_req  (price_req),
        .price_bcd  (price_bcd),
        .msg_req    (msg_req),
        .msg_code   (msg_code),
        .msg_blink  (msg_blink),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .dig4       (dig4),
        .blank      (blank),
        .src        (src),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Nine idle clocks, then one clock with tick_1ms high; blank_pre holds
    // the blank value seen just before the tick edge.
    task automatic do_tick();
        repeat (9) cycle();
        blank_pre = blank;
        tick_1ms = 1'b1;
        cycle();
        tick_1ms = 1'b0;
    endtask

    task automatic send_price(input logic [15:0] p);
        price_req = 1'b1;
        price_bcd = p;
        cycle();
        price_req = 1'b0;
    endtask

    task automatic send_msg(input logic [15:0] c, input logic b);
        msg_req   = 1'b1;
        msg_code  = c;
        msg_blink = b;
        cycle();
        msg_req = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (3) cycle();
        checks++;
        if ({dig_all, blank, src, busy} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got dig=%h blank=%b src=%b busy=%b exp all zero", dig_all, blank, src, busy);
        end
        clr = 1'b1;
        credit_bcd = 16'h0125;
        cycle();
        checks++;
        if (dig_all !== 16'h0125) begin
            errors++;
            $display("FAIL credit_dig got=%h exp=0125", dig_all);
        end
        checks++;
        if ({src, busy, blank} !== 4'b0000) begin
            errors++;
            $display("FAIL credit_flags got src=%b busy=%b blank=%b exp 00/0/0", src, busy, blank);
        end
    endtask

    task automatic test_price();
        send_price(16'h0150);
        checks++;
        if (dig_all !== 16'h0150 || src !== 2'b01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL price_enter got dig=%h src=%b busy=%b exp 0150/01/1", dig_all, src, busy);
        end
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            checks++;
            if (src !== 2'b01 || dig_all !== 16'h0150) begin
                errors++;
                $display("FAIL price_hold tick=%0d got src=%b dig=%h exp 01/0150", k, src, dig_all);
            end
        end
        do_tick();
        checks++;
        if (src !== 2'b00 || busy !== 1'b0 || dig_all !== 16'h0125) begin
            errors++;
            $display("FAIL price_expire got src=%b busy=%b dig=%h exp 00/0/0125", src, busy, dig_all);
        end
    endtask

    task automatic test_msg_blink();
        logic exp_blank [4];
        exp_blank[0] = 1'b0;
        exp_blank[1] = 1'b0;
        exp_blank[2] = 1'b1;
        exp_blank[3] = 1'b1;
        send_msg(16'h5010, 1'b1);
        checks++;
        if (dig_all !== 16'h5010 || src !== 2'b10 || blank !== 1'b0) begin
            errors++;
            $display("FAIL msg_enter got dig=%h src=%b blank=%b exp 5010/10/0", dig_all, src, blank);
        end
        for (int k = 0; k < 4; k++) begin
            do_tick();
            checks++;
            if (blank_pre !== exp_blank[k]) begin
                errors++;
                $display("FAIL msg_blank tick=%0d got=%b exp=%b", k + 1, blank_pre, exp_blank[k]);
            end
        end
        checks++;
        if (src !== 2'b00 || blank !== 1'b0 || dig_all !== 16'h0125) begin
            errors++;
            $display("FAIL msg_expire got src=%b blank=%b dig=%h exp 00/0/0125", src, blank, dig_all);
        end
    endtask

    task automatic test_msg_then_price();
        send_msg(16'hE770, 1'b0);
        do_tick();
        send_price(16'h0300);
        checks++;
        if (src !== 2'b10 || dig_all !== 16'hE770) begin
            errors++;
            $display("FAIL pend_keep_msg got src=%b dig=%h exp 10/e770", src, dig_all);
        end
        for (int k = 2; k <= 3; k++) begin
            do_tick();
            checks++;
            if (src !== 2'b10) begin
                errors++;
                $display("FAIL pend_msg_hold tick=%0d got src=%b exp 10", k, src);
            end
        end
        do_tick();
        checks++;
        if (src !== 2'b01 || dig_all !== 16'h0300) begin
            errors++;
            $display("FAIL pend_to_price got src=%b dig=%h exp 01/0300", src, dig_all);
        end
        repeat (3) do_tick();
        checks++;
        if (src !== 2'b01) begin
            errors++;
            $display("FAIL pend_price_hold got src=%b exp 01", src);
        end
        do_tick();
        checks++;
        if (src !== 2'b00 || dig_all !== 16'h0125) begin
            errors++;
            $display("FAIL pend_price_expire got src=%b dig=%h exp 00/0125", src, dig_all);
        end
    endtask

    task automatic test_preempt();
        send_price(16'h0175);
        do_tick();
        repeat (4) cycle();
        send_msg(16'hF511, 1'b0);
        checks++;
        if (src !== 2'b10 || dig_all !== 16'hF511) begin
            errors++;
            $display("FAIL preempt_enter got src=%b dig=%h exp 10/f511", src, dig_all);
        end
        repeat (3) do_tick();
        checks++;
        if (src !== 2'b10) begin
            errors++;
            $display("FAIL preempt_hold got src=%b exp 10", src);
        end
        do_tick();
        checks++;
        if (src !== 2'b00 || dig_all !== 16'h0125) begin
            errors++;
            $display("FAIL preempt_no_resume got src=%b dig=%h exp 00/0125", src, dig_all);
        end
    endtask

    task automatic test_same_cycle();
        msg_req   = 1'b1;
        msg_code  = 16'h5010;
        msg_blink = 1'b0;
        price_req = 1'b1;
        price_bcd = 16'h0275;
        cycle();
        msg_req   = 1'b0;
        price_req = 1'b0;
        checks++;
        if (src !== 2'b10 || dig_all !== 16'h5010) begin
            errors++;
            $display("FAIL both_req_msg got src=%b dig=%h exp 10/5010", src, dig_all);
        end
        repeat (4) do_tick();
        checks++;
        if (src !== 2'b01 || dig_all !== 16'h0275) begin
            errors++;
            $display("FAIL both_req_price got src=%b dig=%h exp 01/0275", src, dig_all);
        end
        repeat (4) do_tick();
        checks++;
        if (src !== 2'b00) begin
            errors++;
            $display("FAIL both_req_done got src=%b exp 00", src);
        end
    endtask

    task automatic test_retrigger();
        send_price(16'h0100);
        repeat (2) do_tick();
        send_price(16'h0200);
        checks++;
        if (dig_all !== 16'h0200 || src !== 2'b01) begin
            errors++;
            $display("FAIL retrig_data got dig=%h src=%b exp 0200/01", dig_all, src);
        end
        repeat (3) do_tick();
        checks++;
        if (src !== 2'b01) begin
            errors++;
            $display("FAIL retrig_reload got src=%b exp 01", src);
        end
        do_tick();
        checks++;
        if (src !== 2'b00) begin
            errors++;
            $display("FAIL retrig_expire got src=%b exp 00", src);
        end
    endtask

    task automatic test_clr_mid_msg();
        send_msg(16'h5010, 1'b1);
        repeat (2) do_tick();
        checks++;
        if (blank !== 1'b1 || src !== 2'b10) begin
            errors++;
            $display("FAIL clr_pre got blank=%b src=%b exp 1/10", blank, src);
        end
        #2;
        clr = 1'b0;
        #1;
        checks++;
        if ({dig_all, blank, src, busy} !== 20'h0) begin
            errors++;
            $display("FAIL clr_async got dig=%h blank=%b src=%b busy=%b exp all zero", dig_all, blank, src, busy);
        end
        cycle();
        clr = 1'b1;
        credit_bcd = 16'h0350;
        cycle();
        checks++;
        if (dig_all !== 16'h0350 || src !== 2'b00) begin
            errors++;
            $display("FAIL clr_resume got dig=%h src=%b exp 0350/00", dig_all, src);
        end
    endtask

    initial begin
        test_reset();
        test_price();
        test_msg_blink();
        test_msg_then_price();
        test_preempt();
        test_same_cycle();
        test_retrigger();
        test_clr_mid_msg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
